// File: rtl/ecc_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming SECDED engine.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_OK     = 2'b00,
        ECC_CORR   = 2'b01,
        ECC_UNCORR = 2'b10
    } ecc_status_e;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int ecc_par_w(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < (data_w + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

endpackage

// File: rtl/ecc_secded_core.sv
// Combinational SECDED encode/decode. Bit i of a codeword is Hamming position i;
// bit 0 is overall even parity over positions 1..CW_W-1.
module ecc_secded_core
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int PAR_W  = ecc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              mode_i,
    input  logic [CW_W-1:0]   data_i,
    output logic [CW_W-1:0]   result_o,
    output ecc_status_e       status_o,
    output logic [PAR_W-1:0]  syndrome_o
);

    logic [CW_W-1:0]  placed;
    logic [CW_W-1:0]  enc_cw;
    logic [CW_W-1:0]  fixed_cw;
    logic [CW_W-1:0]  msg;
    logic [PAR_W-1:0] place_syn;
    logic [PAR_W-1:0] rx_syn;
    logic             rx_pchk;
    ecc_status_e      rx_status;
    int               j;

    always_comb begin
        placed    = '0;
        enc_cw    = '0;
        fixed_cw  = data_i;
        msg       = '0;
        place_syn = '0;
        rx_syn    = '0;
        rx_pchk   = 1'b0;
        rx_status = ECC_OK;
        j         = 0;

        // Encode: drop data into non-power-of-two slots, then choose each parity
        // bit so that the syndrome of the finished codeword is zero.
        for (int pos = 1; pos < CW_W; pos++) begin
            if (!is_pow2(pos)) begin
                placed[pos] = data_i[j];
                j = j + 1;
            end
        end
        for (int pos = 1; pos < CW_W; pos++) begin
            if (placed[pos]) begin
                place_syn = place_syn ^ PAR_W'(pos);
            end
        end
        enc_cw = placed;
        for (int k = 0; k < PAR_W; k++) begin
            enc_cw[1 << k] = place_syn[k];
        end
        enc_cw[0] = ^enc_cw[CW_W-1:1];

        // Decode: odd overall parity means a single flip at position rx_syn.
        for (int pos = 1; pos < CW_W; pos++) begin
            if (data_i[pos]) begin
                rx_syn = rx_syn ^ PAR_W'(pos);
            end
        end
        rx_pchk = ^data_i;
        if (rx_pchk) begin
            for (int pos = 0; pos < CW_W; pos++) begin
                if (rx_syn == PAR_W'(pos)) begin
                    fixed_cw[pos] = ~data_i[pos];
                end
            end
        end
        if (!rx_pchk) begin
            rx_status = (rx_syn == '0) ? ECC_OK : ECC_UNCORR;
        end else begin
            rx_status = (int'(rx_syn) < CW_W) ? ECC_CORR : ECC_UNCORR;
        end

        j = 0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (!is_pow2(pos)) begin
                msg[j] = fixed_cw[pos];
                j = j + 1;
            end
        end
    end

    always_comb begin
        result_o   = enc_cw;
        status_o   = ECC_OK;
        syndrome_o = '0;
        if (mode_i) begin
            result_o   = msg;
            status_o   = rx_status;
            syndrome_o = rx_syn;
        end
    end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage pipelined SECDED engine with valid/ready flow control and
// saturating corrected/uncorrectable error counters.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = ecc_par_w(DATA_W),
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CW_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_data,
    output logic [1:0]        out_status,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    logic             s1_valid_q;
    logic             s1_mode_q;
    logic [CW_W-1:0]  s1_data_q;
    logic             s2_valid_q;
    logic [CW_W-1:0]  s2_data_q;
    ecc_status_e      s2_status_q;
    logic [PAR_W-1:0] s2_syn_q;
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

    logic [CW_W-1:0]  core_result;
    ecc_status_e      core_status;
    logic [PAR_W-1:0] core_syn;
    logic             adv1, adv2, out_fire;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A stage advances when it is empty or the stage after it advances, so
    // ready ripples back combinationally and a full pipe still accepts one
    // request per cycle while the consumer keeps out_ready high.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;
    assign out_fire = s2_valid_q && out_ready;

    ecc_secded_core #(.DATA_W(DATA_W)) u_core (
        .mode_i     (s1_mode_q),
        .data_i     (s1_data_q),
        .result_o   (core_result),
        .status_o   (core_status),
        .syndrome_o (core_syn)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= in_mode;
                s1_data_q <= in_data;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_status_q <= ECC_OK;
            s2_syn_q    <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q   <= core_result;
                s2_status_q <= core_status;
                s2_syn_q    <= core_syn;
            end
        end
    end

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_fire) begin
            if (s2_status_q == ECC_CORR && cnt_corr_q != '1) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end
            if (s2_status_q == ECC_UNCORR && cnt_uncorr_q != '1) begin
                cnt_uncorr_d = cnt_uncorr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = s2_data_q;
    assign out_status   = s2_status_q;
    assign out_syndrome = s2_syn_q;
    assign cnt_corr     = cnt_corr_q;
    assign cnt_uncorr   = cnt_uncorr_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench: an 8-bit instance for the hand-computed vectors and a 16-bit,
// 2-bit-counter instance for width scaling and counter saturation.
module tb_ecc_secded_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: DATA_W=8, CW_W=13, PAR_W=4, CNT_W=16
    logic        a_in_valid, a_in_ready, a_in_mode;
    logic [12:0] a_in_data;
    logic        a_out_valid, a_out_ready;
    logic [12:0] a_out_data;
    logic [1:0]  a_out_status;
    logic [3:0]  a_out_syn;
    logic        a_cnt_clr;
    logic [15:0] a_cnt_corr, a_cnt_uncorr;

    // Instance B: DATA_W=16, CW_W=22, PAR_W=5, CNT_W=2
    logic        b_in_valid, b_in_ready, b_in_mode;
    logic [21:0] b_in_data;
    logic        b_out_valid, b_out_ready;
    logic [21:0] b_out_data;
    logic [1:0]  b_out_status;
    logic [4:0]  b_out_syn;
    logic        b_cnt_clr;
    logic [1:0]  b_cnt_corr, b_cnt_uncorr;

    logic [18:0] exp_q[$];

    ecc_secded_pipe #(.DATA_W(8), .CNT_W(16)) u_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_status(a_out_status), .out_syndrome(a_out_syn),
        .cnt_clr(a_cnt_clr), .cnt_corr(a_cnt_corr), .cnt_uncorr(a_cnt_uncorr)
    );

    ecc_secded_pipe #(.DATA_W(16), .CNT_W(2)) u_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_status(b_out_status), .out_syndrome(b_out_syn),
        .cnt_clr(b_cnt_clr), .cnt_corr(b_cnt_corr), .cnt_uncorr(b_cnt_uncorr)
    );

    // Independent reference: parity bit b = even parity over positions with bit b set.
    function automatic logic [21:0] ref_encode16(input logic [15:0] d);
        logic [21:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < 22; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 5; b++) begin
            par = 1'b0;
            for (int p = 1; p < 22; p++) begin
                if (((p >> b) & 1) == 1 && p != (1 << b)) par = par ^ cw[p];
            end
            cw[1 << b] = par;
        end
        cw[0] = ^cw[21:1];
        return cw;
    endfunction

    // Drivers: one request with out_ready=1; returns the first valid output and
    // the number of edges from acceptance to out_valid (capped at 10).
    task automatic a_xact(input logic mode, input logic [12:0] data, output logic [12:0] od,
                          output logic [1:0] os, output logic [3:0] osy, output int lat);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_mode   = mode;
        a_in_data   = data;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = a_out_data; os = a_out_status; osy = a_out_syn;
    endtask

    task automatic b_xact(input logic mode, input logic [21:0] data, output logic [21:0] od,
                          output logic [1:0] os, output logic [4:0] osy, output int lat);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_mode   = mode;
        b_in_data   = data;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = b_out_data; os = b_out_status; osy = b_out_syn;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        n_vec++; if ({a_out_data, a_out_status, a_out_syn} !== 19'd0) begin n_err++; $display("FAIL reset_outputs got %h/%b/%h want 0", a_out_data, a_out_status, a_out_syn); end
        n_vec++; if ({a_cnt_corr, a_cnt_uncorr, b_cnt_corr, b_cnt_uncorr} !== 36'd0) begin n_err++; $display("FAIL reset_counters got %0d %0d %0d %0d want 0", a_cnt_corr, a_cnt_uncorr, b_cnt_corr, b_cnt_uncorr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encode;
        logic [12:0] od; logic [1:0] os; logic [3:0] osy; int lat;
        a_xact(1'b0, 13'h004B, od, os, osy, lat);
        n_vec++; if (od !== 13'h09AC) begin n_err++; $display("FAIL enc_4b_data got %h want 09ac", od); end
        n_vec++; if (os !== 2'b00 || osy !== 4'd0) begin n_err++; $display("FAIL enc_4b_status got %b/%0d want 00/0", os, osy); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL enc_latency got %0d want 2", lat); end
        a_xact(1'b0, 13'h1F4B, od, os, osy, lat);
        n_vec++; if (od !== 13'h09AC) begin n_err++; $display("FAIL enc_upper_ignored got %h want 09ac", od); end
        a_xact(1'b0, 13'h00FF, od, os, osy, lat);
        n_vec++; if (od !== 13'h1EEE) begin n_err++; $display("FAIL enc_ff_data got %h want 1eee", od); end
        @(posedge clk); #1;
        n_vec++; if (a_cnt_corr !== 16'd0 || a_cnt_uncorr !== 16'd0) begin n_err++; $display("FAIL enc_no_count got %0d/%0d want 0/0", a_cnt_corr, a_cnt_uncorr); end
    endtask

    task automatic test_decode_corr;
        logic [12:0] od; logic [1:0] os; logic [3:0] osy; int lat;
        a_xact(1'b1, 13'h09EC, od, os, osy, lat);
        n_vec++; if (od !== 13'h004B) begin n_err++; $display("FAIL dec_bit6_data got %h want 004b", od); end
        n_vec++; if (os !== 2'b01 || osy !== 4'd6) begin n_err++; $display("FAIL dec_bit6_status got %b/%0d want 01/6", os, osy); end
        @(posedge clk); #1;
        n_vec++; if (a_cnt_corr !== 16'd1 || a_cnt_uncorr !== 16'd0) begin n_err++; $display("FAIL dec_bit6_cnt got %0d/%0d want 1/0", a_cnt_corr, a_cnt_uncorr); end
    endtask

    task automatic test_decode_uncorr;
        logic [12:0] od; logic [1:0] os; logic [3:0] osy; int lat;
        a_xact(1'b1, 13'h09E4, od, os, osy, lat);
        n_vec++; if (os !== 2'b10 || osy !== 4'd5) begin n_err++; $display("FAIL dec_double_status got %b/%0d want 10/5", os, osy); end
        n_vec++; if (od !== 13'h004E) begin n_err++; $display("FAIL dec_double_data got %h want 004e", od); end
        @(posedge clk); #1;
        n_vec++; if (a_cnt_uncorr !== 16'd1 || a_cnt_corr !== 16'd1) begin n_err++; $display("FAIL dec_double_cnt got %0d/%0d want 1/1", a_cnt_corr, a_cnt_uncorr); end
        a_xact(1'b1, 13'h09AD, od, os, osy, lat);
        n_vec++; if (od !== 13'h004B || os !== 2'b01 || osy !== 4'd0) begin n_err++; $display("FAIL dec_bit0 got %h/%b/%0d want 004b/01/0", od, os, osy); end
        // three parity flips (1,4,8): odd parity but syndrome 13 is past the codeword
        a_xact(1'b1, 13'h08BE, od, os, osy, lat);
        n_vec++; if (od !== 13'h004B || os !== 2'b10 || osy !== 4'd13) begin n_err++; $display("FAIL dec_syn_oob got %h/%b/%0d want 004b/10/13", od, os, osy); end
        @(posedge clk); #1;
        n_vec++; if (a_cnt_corr !== 16'd2 || a_cnt_uncorr !== 16'd2) begin n_err++; $display("FAIL dec_mixed_cnt got %0d/%0d want 2/2", a_cnt_corr, a_cnt_uncorr); end
    endtask

    task automatic test_back_to_back;
        logic        vmode [8];
        logic [12:0] vin   [8];
        logic [18:0] vexp  [8];
        logic [3:0]  rdy_pat;
        logic        acc, fire, stall;
        logic [18:0] held, got;
        int          idx, inflight, cyc;
        // expected packed as {status, syndrome, data}
        vmode[0] = 0; vin[0] = 13'h004B; vexp[0] = {2'b00, 4'd0,  13'h09AC};
        vmode[1] = 1; vin[1] = 13'h09EC; vexp[1] = {2'b01, 4'd6,  13'h004B};
        vmode[2] = 1; vin[2] = 13'h09AC; vexp[2] = {2'b00, 4'd0,  13'h004B};
        vmode[3] = 1; vin[3] = 13'h09E4; vexp[3] = {2'b10, 4'd5,  13'h004E};
        vmode[4] = 0; vin[4] = 13'h0000; vexp[4] = {2'b00, 4'd0,  13'h0000};
        vmode[5] = 1; vin[5] = 13'h09AD; vexp[5] = {2'b01, 4'd0,  13'h004B};
        vmode[6] = 1; vin[6] = 13'h08BE; vexp[6] = {2'b10, 4'd13, 13'h004B};
        vmode[7] = 0; vin[7] = 13'h00FF; vexp[7] = {2'b00, 4'd0,  13'h1EEE};
        rdy_pat  = 4'b1001;
        idx = 0; inflight = 0; acc = 0; stall = 0; held = '0;
        exp_q.delete();
        for (cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            if (acc) idx++;
            if (stall) begin
                n_vec++;
                if (a_out_valid !== 1'b1 || {a_out_status, a_out_syn, a_out_data} !== held) begin
                    n_err++; $display("FAIL b2b_stall_hold got %b/%h want 1/%h", a_out_valid, {a_out_status, a_out_syn, a_out_data}, held);
                end
            end
            if (idx == 8 && inflight == 0) break;
            a_out_ready = rdy_pat[cyc % 4];
            a_in_valid  = (idx < 8);
            a_in_mode   = (idx < 8) ? vmode[idx] : 1'b0;
            a_in_data   = (idx < 8) ? vin[idx] : 13'h0;
            #1;
            n_vec++;
            if (a_in_ready !== !(inflight == 2 && !a_out_ready)) begin
                n_err++; $display("FAIL b2b_in_ready got %b want %b (inflight %0d)", a_in_ready, !(inflight == 2 && !a_out_ready), inflight);
            end
            acc   = a_in_valid && a_in_ready;
            fire  = a_out_valid && a_out_ready;
            stall = a_out_valid && !a_out_ready;
            held  = {a_out_status, a_out_syn, a_out_data};
            if (fire) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_output got %h want none", held);
                end else begin
                    got = exp_q.pop_front();
                    if (held !== got) begin n_err++; $display("FAIL b2b_output got %h want %h", held, got); end
                end
            end
            if (acc) exp_q.push_back(vexp[idx]);
            inflight = inflight + (acc ? 1 : 0) - (fire ? 1 : 0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        n_vec++; if (idx != 8 || inflight != 0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain got idx %0d inflight %0d pending %0d want 8/0/0", idx, inflight, exp_q.size()); end
        n_vec++; if (a_cnt_corr !== 16'd4 || a_cnt_uncorr !== 16'd4) begin n_err++; $display("FAIL b2b_cnt got %0d/%0d want 4/4", a_cnt_corr, a_cnt_uncorr); end
    endtask

    task automatic test_wide_encode;
        logic [15:0] vd [4];
        logic [21:0] od; logic [1:0] os; logic [4:0] osy; int lat;
        vd[0] = 16'h0000; vd[1] = 16'hFFFF; vd[2] = 16'hA5C3; vd[3] = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            b_xact(1'b0, {6'h3F, vd[i]}, od, os, osy, lat);
            n_vec++; if (od !== ref_encode16(vd[i]) || os !== 2'b00 || osy !== 5'd0 || lat !== 2) begin
                n_err++; $display("FAIL wide_enc_%0d got %h/%b/%0d/lat%0d want %h/00/0/lat2", i, od, os, osy, lat, ref_encode16(vd[i]));
            end
        end
        @(posedge clk); #1;
        n_vec++; if (b_cnt_corr !== 2'd0 || b_cnt_uncorr !== 2'd0) begin n_err++; $display("FAIL wide_enc_cnt got %0d/%0d want 0/0", b_cnt_corr, b_cnt_uncorr); end
    endtask

    task automatic test_counters;
        logic [15:0] vd [5];
        int          vflip [5];
        logic [21:0] cw, od; logic [1:0] os; logic [4:0] osy; int lat;
        vd[0] = 16'h1357; vd[1] = 16'h8001; vd[2] = 16'hBEEF; vd[3] = 16'h0F0F; vd[4] = 16'h4B4B;
        vflip[0] = 3; vflip[1] = 10; vflip[2] = 21; vflip[3] = 1; vflip[4] = 16;
        for (int i = 0; i < 5; i++) begin
            cw = ref_encode16(vd[i]) ^ (22'd1 << vflip[i]);
            b_xact(1'b1, cw, od, os, osy, lat);
            n_vec++; if (od !== {6'd0, vd[i]} || os !== 2'b01 || osy !== 5'(vflip[i])) begin
                n_err++; $display("FAIL cnt_dec_%0d got %h/%b/%0d want %h/01/%0d", i, od, os, osy, {6'd0, vd[i]}, vflip[i]);
            end
            @(posedge clk); #1;
            n_vec++; if (b_cnt_corr !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                n_err++; $display("FAIL cnt_sat_%0d got %0d want %0d", i, b_cnt_corr, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        cw = ref_encode16(16'h00A5) ^ (22'd1 << 5);
        b_xact(1'b1, cw, od, os, osy, lat);
        b_cnt_clr = 1'b1;
        @(posedge clk); #1;
        b_cnt_clr = 1'b0;
        n_vec++; if (b_cnt_corr !== 2'd0) begin n_err++; $display("FAIL cnt_clr_priority got %0d want 0", b_cnt_corr); end
        cw = ref_encode16(16'h00A5) ^ (22'd1 << 5);
        b_xact(1'b1, cw, od, os, osy, lat);
        @(posedge clk); #1;
        n_vec++; if (b_cnt_corr !== 2'd1) begin n_err++; $display("FAIL cnt_after_clr got %0d want 1", b_cnt_corr); end
        cw = ref_encode16(16'h00A5) ^ (22'd1 << 3) ^ (22'd1 << 5);
        b_xact(1'b1, cw, od, os, osy, lat);
        n_vec++; if (os !== 2'b10 || osy !== 5'd6) begin n_err++; $display("FAIL wide_double got %b/%0d want 10/6", os, osy); end
        @(posedge clk); #1;
        n_vec++; if (b_cnt_uncorr !== 2'd1 || b_cnt_corr !== 2'd1) begin n_err++; $display("FAIL wide_uncorr_cnt got %0d/%0d want 1/1", b_cnt_corr, b_cnt_uncorr); end
    endtask

    task automatic test_reset_midflight;
        logic [12:0] od; logic [1:0] os; logic [3:0] osy; int lat;
        int          stale;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 1'b0;
        a_in_data   = 13'h004B;
        @(posedge clk); #1;
        a_in_data = 13'h00FF;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL rst_full_pipe got ready %b valid %b want 0/1", a_in_ready, a_out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_async got valid %b ready %b want 0/1", a_out_valid, a_in_ready); end
        n_vec++; if (a_out_data !== 13'h0 || a_cnt_corr !== 16'd0 || a_cnt_uncorr !== 16'd0 || b_cnt_uncorr !== 2'd0) begin
            n_err++; $display("FAIL rst_clear got data %h cnt %0d/%0d/%0d want 0", a_out_data, a_cnt_corr, a_cnt_uncorr, b_cnt_uncorr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b0) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL rst_stale_output got %0d valid cycles want 0", stale); end
        a_xact(1'b0, 13'h004B, od, os, osy, lat);
        n_vec++; if (od !== 13'h09AC || lat !== 2) begin n_err++; $display("FAIL rst_recover got %h/lat%0d want 09ac/lat2", od, lat); end
    endtask

    initial begin
        a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1; a_cnt_clr = 0;
        b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1; b_cnt_clr = 0;
        test_reset();
        test_encode();
        test_decode_corr();
        test_decode_uncorr();
        test_back_to_back();
        test_wide_encode();
        test_counters();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined extended-Hamming SECDED encode/decode engine for the user project area.
- Generalises the fixed 8-bit ECC encoder/decoder that firmware drives over the logic analyser.
- Adds: configurable data width, per-transaction encode/decode mode, valid/ready handshake with back-pressure, status and syndrome reporting, and saturating error counters readable over LA.

Parameters:
- DATA_W, 8, message width in bits (>=4).
- PAR_W, derived: smallest r with 2^r >= DATA_W+r+1 (4 for DATA_W=8); not user-overridable.
- CW_W, derived: DATA_W+PAR_W+1 (13 for DATA_W=8).
- CNT_W, 16, width of each error counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_mode  in  1  0=encode, 1=decode
- in_data  in  CW_W  encode: message in [DATA_W-1:0], upper bits ignored; decode: received codeword
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_data  out  CW_W  encode: codeword; decode: corrected message zero-extended
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 never driven
- out_syndrome  out  PAR_W  Hamming syndrome (0 for encode)
- cnt_clr  in  1  synchronous clear of both counters
- cnt_corr  out  CNT_W  corrected-error count
- cnt_uncorr  out  CNT_W  uncorrectable-error count

Behaviour:
- Codeword layout:
  - bit i = Hamming position i for i=1..CW_W-1.
  - Parity bits sit at power-of-two positions; parity p_k covers every position whose index has bit k set (even parity).
  - Data bits d0..d(DATA_W-1) fill the non-power-of-two positions in ascending order.
  - Bit 0 is overall even parity over bits 1..CW_W-1.
- Decode:
  - syn = XOR of position indices of all set bits 1..CW_W-1; pchk = XOR of all CW_W bits.
  - syn=0, pchk=0 -> status 00.
  - pchk=1 -> status 01; flip position syn (syn=0 means bit 0 flipped, data unaffected).
  - syn!=0, pchk=0 -> status 10; data output is the uncorrected extraction.
  - syn pointing beyond CW_W-1 with pchk=1 -> status 10.
- Pipeline, two register stages:
  - S1 captures mode and data.
  - S2 captures the combinational encode/decode result from S1.
  - Latency: request accepted on edge t -> out_valid high after edge t+1.
  - Throughput: 1 per cycle.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational through the stages; no bubble).
  - out_* held stable while out_valid && !out_ready.
  - in_valid may drop without acceptance; no requirement on in_data stability before acceptance.
- Counters:
  - Increment cnt_corr / cnt_uncorr on each output handshake with status 01 / 10.
  - Saturate at all-ones; no wrap.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset, asynchronous assert, synchronous-safe deassert:
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_status=00, out_syndrome=0, counters=0.
  - in_ready=1 after reset.
  - Reset mid-transaction discards all in-flight data with no output.
- Encode never changes counters; its status is always 00.

Decomposition:
- Package ecc_pkg:
  - status enum ECC_OK/ECC_CORR/ECC_UNCORR.
  - function ecc_par_w(data_w).
  - function is_pow2(pos).
- Sub-module ecc_secded_core: purely combinational, parametrised by DATA_W.
  - Inputs: mode, data.
  - Outputs: result, status, syndrome.
- ecc_secded_pipe holds the stages, handshake and counters.

Test Plan:
- Encode 0x4B, out_ready=1 -> out_data=0x09AC, status 00, syndrome 0, out_valid exactly 2 edges after acceptance.
- Decode 0x09EC (bit6 flipped) -> data 0x004B, status 01, syndrome 6, cnt_corr=1.
- Decode 0x09E4 (bits 3 and 6 flipped) -> status 10, syndrome 5, cnt_uncorr=1; decode 0x09AD -> data 0x4B, status 01, syndrome 0.
- Back-to-back stream of 8 mixed requests with out_ready toggled 1,0,0,1,…:
  - No loss or duplication.
  - out_* stable while stalled.
  - in_ready low only when both stages are full and out_ready=0.
- Counters, CNT_W=2:
  - 5 corrected decodes -> cnt_corr=3 (saturated).
  - cnt_clr asserted on the same cycle as a corrected handshake -> 0.
- Reset asserted with both stages full -> out_valid drops immediately, counters 0, no stale output after release; repeat the encode test at DATA_W=16 (CW_W=22) against a reference model.
